// File: rtl/me_dcache_seq_pkg.sv
// ---------------------------------------------------------------------------
// me_dcache_seq_pkg
// Shared constants and helpers for the ME data-cache access sequencer.
//   - beat geometry of a wide (matrix row) access
//   - 6-bit sequencer state codes reported to the ME controller
//   - scalar size codes
//   - address forcing / misalignment helpers used at request accept
// Configuration macro consumed by users of this package:
//   DCACHE_MISALIGN_CHECK_EN (see me_dcache_seq)
// ---------------------------------------------------------------------------
package me_dcache_seq_pkg;

   localparam int BEATS  = 16;          // 32-bit beats per wide op
   localparam int CNT_W  = 4;           // beat counter width
   localparam int WIDE_W = BEATS * 32;  // wide data width in bits

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Sequencer state codes; FREE is the only code that lets ME proceed.
   localparam logic [5:0] STATE_FREE   = 6'd0;
   localparam logic [5:0] STATE_SCALAR = 6'd1;
   localparam logic [5:0] STATE_WIDE   = 6'd2;
   localparam logic [5:0] STATE_DONE   = 6'd3;

   // Scalar access sizes; the unused code 3 is handled as a word.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Clear the low address bits an access of this shape may not have set.
   function automatic logic [31:0] align_addr(input logic        wide,
                                              input logic [1:0]  size,
                                              input logic [31:0] addr);
      logic [31:0] a;
      a = addr;
      if (wide) begin
         a[5:0] = 6'd0;
      end else begin
         case (size)
            SZ_B:    a = addr;
            SZ_H:    a[0] = 1'b0;
            default: a[1:0] = 2'b00;
         endcase
      end
      return a;
   endfunction

   // True when the address has low bits set that the access shape forbids.
   function automatic logic is_misaligned(input logic        wide,
                                          input logic [1:0]  size,
                                          input logic [31:0] addr);
      logic bad;
      if (wide) begin
         bad = |addr[5:0];
      end else begin
         case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr[0];
            default: bad = |addr[1:0];
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/me_dcache_seq_lane_align.sv
// ---------------------------------------------------------------------------
// me_lane_align
// Combinational byte-lane steering for scalar accesses.
// Ports:
//   st_size_i  in   2   size of the store being accepted
//   st_off_i   in   2   byte offset (addr[1:0]) of the store
//   st_data_i  in   32  raw store data, right-aligned
//   st_data_o  out  32  store data replicated across the word (B x4, H x2)
//   st_strb_o  out  4   byte enables for the store
//   ld_size_i  in   2   size of the load in flight
//   ld_off_i   in   2   byte offset of the load
//   ld_data_i  in   32  word returned by the cache
//   ld_data_o  out  32  load result, right-aligned and zero-extended
// ---------------------------------------------------------------------------
module me_lane_align
   import me_dcache_seq_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_data_o,
   output logic [3:0]  st_strb_o,
   input  logic [1:0]  ld_size_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_data_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift_s;

   // Store path: replicate the datum so every enabled lane sees it.
   always_comb begin
      st_data_o = 32'd0;
      st_strb_o = 4'd0;
      case (st_size_i)
         SZ_B: begin
            st_data_o = {4{st_data_i[7:0]}};
            st_strb_o = 4'b0001 << st_off_i;
         end
         SZ_H: begin
            st_data_o = {2{st_data_i[15:0]}};
            st_strb_o = 4'b0011 << {st_off_i[1], 1'b0};
         end
         default: begin
            st_data_o = st_data_i;
            st_strb_o = 4'b1111;
         end
      endcase
   end

   // Load path: bring the addressed lane down to bit 0, then mask to size.
   always_comb begin
      ld_shift_s = ld_data_i >> {ld_off_i, 3'b000};
      ld_data_o  = 32'd0;
      case (ld_size_i)
         SZ_B:    ld_data_o = {24'd0, ld_shift_s[7:0]};
         SZ_H:    ld_data_o = {16'd0, ld_shift_s[15:0]};
         default: ld_data_o = ld_shift_s;
      endcase
   end

endmodule

// File: rtl/me_dcache_seq.sv
// ---------------------------------------------------------------------------
// me_dcache_seq
// Memory-stage access sequencer between the ME pipeline controller and the
// data cache port. One scalar (B/H/W) or wide (512-bit) load/store per
// request; wide ops run as 16 sequential 32-bit beats. ME stalls while
// state_o differs from STATE_FREE.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only in FREE)
//   req_we_i, req_wide_i     store / wide select
//   req_size_i               scalar size (B/H/W), ignored when wide
//   req_addr_i, req_wdata_i  byte address, store data (scalar in [31:0])
//   state_o                  6-bit sequencer state code
//   mem_req_o .. mem_wstrb_o cache beat request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i   beat completion and read data
//   rsp_valid_o              one-cycle completion pulse
//   rsp_rdata_o              load result, held until the next accept
//   rsp_err_o                access fault
// Configuration:
//   DCACHE_MISALIGN_CHECK_EN defined   - misaligned requests fault without
//                                        touching the cache (rsp_err_o=1).
//   DCACHE_MISALIGN_CHECK_EN undefined - offending low address bits are
//                                        forced to zero; rsp_err_o stays 0.
// ---------------------------------------------------------------------------
module me_dcache_seq
   import me_dcache_seq_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic              req_wide_i,
   input  logic [1:0]        req_size_i,
   input  logic [31:0]       req_addr_i,
   input  logic [WIDE_W-1:0] req_wdata_i,
   output logic [5:0]        state_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wstrb_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              rsp_valid_o,
   output logic [WIDE_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o
);

   logic [5:0]        state_q, state_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [WIDE_W-1:0] wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [WIDE_W-1:0] rdata_q, rdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;

   logic              accept_s;
   logic              beat_done_s;
   logic              fault_s;
   logic [31:0]       addr_al_s;
   logic [CNT_W-1:0]  beat_inc_s;
   logic [31:0]       st_wdata_s;
   logic [3:0]        st_wstrb_s;
   logic [31:0]       ld_rdata_s;

   assign accept_s    = req_valid_i & (state_q == STATE_FREE);
   // An ack only counts while a beat is actually being requested.
   assign beat_done_s = mem_req_q & mem_ack_i;
   assign beat_inc_s  = beat_q + 4'd1;
   assign addr_al_s   = align_addr(req_wide_i, req_size_i, req_addr_i);

`ifdef DCACHE_MISALIGN_CHECK_EN
   assign fault_s = is_misaligned(req_wide_i, req_size_i, req_addr_i);
`else
   assign fault_s = 1'b0;
`endif

   // Store lanes come from the live request; load lanes from the captured op.
   me_lane_align u_lane_align (
      .st_size_i (req_size_i),
      .st_off_i  (addr_al_s[1:0]),
      .st_data_i (req_wdata_i[31:0]),
      .st_data_o (st_wdata_s),
      .st_strb_o (st_wstrb_s),
      .ld_size_i (size_q),
      .ld_off_i  (off_q),
      .ld_data_i (mem_rdata_i),
      .ld_data_o (ld_rdata_s)
   );

   // Next-state logic: FSM, beat counter, cache port and result assembly.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         STATE_FREE: begin
            if (accept_s) begin
               // Capture the whole request; the ME side may change it now.
               beat_d    = {CNT_W{1'b0}};
               mem_we_d  = req_we_i;
               wdata_d   = req_wdata_i;
               size_d    = req_size_i;
               off_d     = addr_al_s[1:0];
               rdata_d   = {WIDE_W{1'b0}};
               rsp_err_d = fault_s;
               if (req_wide_i) begin
                  mem_addr_d  = {addr_al_s[31:6], 6'd0};
                  mem_wdata_d = req_wdata_i[31:0];
                  mem_wstrb_d = 4'b1111;
               end else begin
                  mem_addr_d  = {addr_al_s[31:2], 2'd0};
                  mem_wdata_d = st_wdata_s;
                  mem_wstrb_d = req_we_i ? st_wstrb_s : 4'b1111;
               end
               if (fault_s) begin
                  // Faulting op never reaches the cache.
                  state_d     = STATE_DONE;
                  mem_req_d   = 1'b0;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d   = req_wide_i ? STATE_WIDE : STATE_SCALAR;
                  mem_req_d = 1'b1;
               end
            end else begin
               mem_req_d = 1'b0;
            end
         end
         STATE_SCALAR: begin
            if (beat_done_s) begin
               state_d     = STATE_DONE;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               if (!mem_we_q) begin
                  rdata_d[31:0] = ld_rdata_s;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = STATE_SCALAR;
            end
         end
         STATE_WIDE: begin
            if (beat_done_s) begin
               if (!mem_we_q) begin
                  rdata_d[{beat_q, 5'd0} +: 32] = mem_rdata_i;
               end else begin
                  rdata_d = rdata_q;
               end
               if (beat_q == LAST_BEAT) begin
                  state_d     = STATE_DONE;
                  mem_req_d   = 1'b0;
                  rsp_valid_d = 1'b1;
               end else begin
                  // Keep mem_req high; the next beat is presented next cycle.
                  beat_d      = beat_inc_s;
                  mem_addr_d  = mem_addr_q + 32'd4;
                  mem_wdata_d = wdata_q[{beat_inc_s, 5'd0} +: 32];
               end
            end else begin
               state_d = STATE_WIDE;
            end
         end
         STATE_DONE: begin
            state_d   = STATE_FREE;
            mem_req_d = 1'b0;
         end
         default: begin
            state_d   = STATE_FREE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= STATE_FREE;
         beat_q      <= {CNT_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_wstrb_q <= 4'd0;
         wdata_q     <= {WIDE_W{1'b0}};
         size_q      <= SZ_B;
         off_q       <= 2'd0;
         rdata_q     <= {WIDE_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready_o = (state_q == STATE_FREE);
   assign state_o     = state_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wstrb_o = mem_wstrb_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_me_dcache_seq.sv
// ---------------------------------------------------------------------------
// tb_me_dcache_seq
// Directed bench for me_dcache_seq: a table of scalar accesses with
// hand-computed cache-port and response values, plus hand-written
// sequences for wide loads/stores, ack stalls and mid-op reset.
// Honours DCACHE_MISALIGN_CHECK_EN for the misaligned-address vectors.
// ---------------------------------------------------------------------------
module tb_me_dcache_seq;
   import me_dcache_seq_pkg::*;

`ifdef DCACHE_MISALIGN_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic         req_we_i;
   logic         req_wide_i;
   logic [1:0]   req_size_i;
   logic [31:0]  req_addr_i;
   logic [511:0] req_wdata_i;
   logic [5:0]   state_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [31:0]  mem_wdata_o;
   logic [3:0]   mem_wstrb_o;
   logic         mem_ack_i;
   logic [31:0]  mem_rdata_i;
   logic         rsp_valid_o;
   logic [511:0] rsp_rdata_o;
   logic         rsp_err_o;

   int nchk = 0;
   int nerr = 0;

   me_dcache_seq dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_wide_i  (req_wide_i),
      .req_size_i  (req_size_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .state_o     (state_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_wstrb_o (mem_wstrb_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;     // word the cache returns
      int          dly;       // cycles of mem_req before ack
      logic        misal;     // address violates alignment for its size
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rsp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic exp_fault;
      int   nreq;
      int   got_c;
      exp_fault = v.misal & CHK_EN;
      nreq  = 0;
      got_c = -1;
      @(negedge clk);
      chk({nm, "_ready"}, req_ready_o, 1'b1);
      req_valid_i = 1'b1;
      req_we_i    = v.we;
      req_wide_i  = 1'b0;
      req_size_i  = v.size;
      req_addr_i  = v.addr;
      req_wdata_i = {480'd0, v.wdata};
      @(negedge clk);
      req_valid_i = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         mem_ack_i = 1'b0;
         if (rsp_valid_o) begin
            got_c = c;
            break;
         end
         if (mem_req_o) begin
            nreq++;
            if (nreq == 1) begin
               chk({nm, "_addr"}, mem_addr_o, v.exp_addr);
               chk({nm, "_we"}, mem_we_o, v.we);
               chk({nm, "_strb"}, mem_wstrb_o, v.exp_strb);
               if (v.we) chk({nm, "_wdata"}, mem_wdata_o, v.exp_wdata);
            end
            if (nreq > v.dly) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = v.rdata;
            end
         end
         @(negedge clk);
      end
      chk({nm, "_latency"}, got_c, exp_fault ? 1 : v.dly + 2);
      chk({nm, "_nreq"}, nreq, exp_fault ? 0 : v.dly + 1);
      chk({nm, "_done"}, state_o, STATE_DONE);
      chk({nm, "_err"}, rsp_err_o, exp_fault);
      if (!v.we || exp_fault) chk({nm, "_rdata"}, rsp_rdata_o, exp_fault ? 512'd0 : {480'd0, v.exp_rsp});
      @(negedge clk);
      chk({nm, "_free"}, state_o, STATE_FREE);
      chk({nm, "_pulse"}, rsp_valid_o, 1'b0);
      if (!v.we && !exp_fault) chk({nm, "_hold"}, rsp_rdata_o, {480'd0, v.exp_rsp});
   endtask

   initial begin : main
      logic [511:0] exp_wide;
      logic [511:0] st_wide;
      int nbeat;
      int rsp_c;
      int npulse;
      logic        p_req, p_ack;
      logic [31:0] p_addr, p_wdata;
      logic [3:0]  p_strb;

      //           we    size  addr      wdata         rdata         dly mis  exp_addr  strb     exp_wdata     exp_rsp
      vecs[0]  = '{1'b0, SZ_W, 32'h100, 32'h0,        32'hDEADBEEF, 2,  1'b0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF};
      vecs[1]  = '{1'b1, SZ_B, 32'h103, 32'hAB,       32'h0,        0,  1'b0, 32'h100, 4'b1000, 32'hABABABAB, 32'h0};
      vecs[2]  = '{1'b0, SZ_B, 32'h101, 32'h0,        32'h11223344, 1,  1'b0, 32'h100, 4'b1111, 32'h0,        32'h33};
      vecs[3]  = '{1'b0, SZ_H, 32'h102, 32'h0,        32'hA1B2C3D4, 0,  1'b0, 32'h100, 4'b1111, 32'h0,        32'hA1B2};
      vecs[4]  = '{1'b1, SZ_H, 32'h102, 32'h12345678, 32'h0,        3,  1'b0, 32'h100, 4'b1100, 32'h56785678, 32'h0};
      vecs[5]  = '{1'b1, SZ_W, 32'h204, 32'hCAFEF00D, 32'h0,        1,  1'b0, 32'h204, 4'b1111, 32'hCAFEF00D, 32'h0};
      vecs[6]  = '{1'b0, SZ_B, 32'h203, 32'h0,        32'h8899AABB, 0,  1'b0, 32'h200, 4'b1111, 32'h0,        32'h88};
      vecs[7]  = '{1'b1, SZ_B, 32'h200, 32'hFFFF12C3, 32'h0,        0,  1'b0, 32'h200, 4'b0001, 32'hC3C3C3C3, 32'h0};
      vecs[8]  = '{1'b0, SZ_W, 32'h102, 32'h0,        32'h55667788, 1,  1'b1, 32'h100, 4'b1111, 32'h0,        32'h55667788};
      vecs[9]  = '{1'b0, SZ_H, 32'h103, 32'h0,        32'hA1B2C3D4, 0,  1'b1, 32'h100, 4'b1111, 32'h0,        32'hA1B2};
      vecs[10] = '{1'b1, SZ_H, 32'h101, 32'h0000BEEF, 32'h0,        0,  1'b1, 32'h100, 4'b0011, 32'hBEEFBEEF, 32'h0};

      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_wide_i  = 1'b0;
      req_size_i  = SZ_B;
      req_addr_i  = 32'd0;
      req_wdata_i = 512'd0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'd0;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;

      // Reset state
      chk("rst_state", state_o, STATE_FREE);
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_rsp_err", rsp_err_o, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata_o, 512'd0);

      // Stray ack while idle is ignored
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      chk("idle_ack_state", state_o, STATE_FREE);
      chk("idle_ack_rsp", rsp_valid_o, 1'b0);

      // Scalar table
      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Wide load at 0x40, ack every cycle, beat k returns k
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_wide_i  = 1'b1;
      req_size_i  = SZ_W;
      req_addr_i  = 32'h40;
      @(negedge clk);
      req_valid_i = 1'b0;
      nbeat = 0;
      rsp_c = -1;
      for (int c = 1; c <= 40; c++) begin
         mem_ack_i = 1'b0;
         if (rsp_valid_o) begin
            rsp_c = c;
            break;
         end
         if (mem_req_o) begin
            chk($sformatf("wl_addr%0d", nbeat), mem_addr_o, 32'h40 + 32'(4 * nbeat));
            chk("wl_strb", mem_wstrb_o, 4'b1111);
            chk("wl_we", mem_we_o, 1'b0);
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'(nbeat);
            nbeat++;
         end
         @(negedge clk);
      end
      exp_wide = 512'd0;
      for (int k = 0; k < 16; k++) exp_wide[32*k +: 32] = 32'(k);
      chk("wl_rsp_cycle", rsp_c, 17);
      chk("wl_beats", nbeat, 16);
      chk("wl_rdata", rsp_rdata_o, exp_wide);
      @(negedge clk);
      chk("wl_free", state_o, STATE_FREE);
      chk("wl_pulse", rsp_valid_o, 1'b0);

      // Wide store at 0x1C0 with random ack stalls and ignored req pulses
      for (int k = 0; k < 16; k++) st_wide[32*k +: 32] = 32'hA5A50000 | 32'(k);
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i    = 1'b1;
      req_wide_i  = 1'b1;
      req_addr_i  = 32'h1C0;
      req_wdata_i = st_wide;
      @(negedge clk);
      req_valid_i = 1'b0;
      req_addr_i  = 32'h300;
      req_wdata_i = 512'd0;
      nbeat  = 0;
      npulse = 0;
      rsp_c  = -1;
      p_req  = 1'b0;
      p_ack  = 1'b0;
      p_addr = 32'd0;
      p_wdata = 32'd0;
      p_strb = 4'd0;
      for (int c = 1; c <= 200; c++) begin
         mem_ack_i   = 1'b0;
         req_valid_i = 1'b0;
         if (rsp_valid_o) begin
            rsp_c = c;
            break;
         end
         if (mem_req_o) begin
            chk("ws_ready_low", req_ready_o, 1'b0);
            if (p_req && !p_ack) begin
               chk("ws_hold_addr", mem_addr_o, p_addr);
               chk("ws_hold_wdata", mem_wdata_o, p_wdata);
               chk("ws_hold_strb", mem_wstrb_o, p_strb);
            end
            if (c % 3 == 0) begin
               req_valid_i = 1'b1;
               npulse++;
            end
            mem_ack_i = ($urandom_range(0, 2) == 0);
            if (mem_ack_i) begin
               chk($sformatf("ws_addr%0d", nbeat), mem_addr_o, 32'h1C0 + 32'(4 * nbeat));
               chk($sformatf("ws_wdata%0d", nbeat), mem_wdata_o, st_wide[32*nbeat +: 32]);
               chk("ws_strb", mem_wstrb_o, 4'b1111);
               chk("ws_we", mem_we_o, 1'b1);
               nbeat++;
            end
         end
         p_req   = mem_req_o;
         p_ack   = mem_ack_i;
         p_addr  = mem_addr_o;
         p_wdata = mem_wdata_o;
         p_strb  = mem_wstrb_o;
         @(negedge clk);
      end
      mem_ack_i   = 1'b0;
      req_valid_i = 1'b0;
      chk("ws_done_seen", rsp_c > 0, 1'b1);
      chk("ws_beats", nbeat, 16);
      chk("ws_pulses_sent", npulse > 0, 1'b1);
      @(negedge clk);
      chk("ws_free", state_o, STATE_FREE);
      @(negedge clk);
      chk("ws_no_accept", mem_req_o, 1'b0);
      chk("ws_no_accept_state", state_o, STATE_FREE);

      // Reset while beat 7 of a wide load is outstanding
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_wide_i  = 1'b1;
      req_addr_i  = 32'h80;
      @(negedge clk);
      req_valid_i = 1'b0;
      nbeat = 0;
      for (int c = 1; c <= 40; c++) begin
         mem_ack_i = 1'b0;
         if (mem_req_o && nbeat == 7) begin
            chk("rs_beat7_addr", mem_addr_o, 32'h9C);
            rst_i = 1'b1;
            break;
         end
         if (mem_req_o) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'h77000000 | 32'(nbeat);
            nbeat++;
         end
         @(negedge clk);
      end
      chk("rs_reached_beat7", rst_i, 1'b1);
      @(negedge clk);
      rst_i = 1'b0;
      chk("rs_mem_req", mem_req_o, 1'b0);
      chk("rs_state", state_o, STATE_FREE);
      chk("rs_rsp_valid", rsp_valid_o, 1'b0);
      @(negedge clk);
      chk("rs_rsp_valid2", rsp_valid_o, 1'b0);
      run_vec(vecs[0], "rs_lw");

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
